trigger_router: RTL and testbench

TRIGGER_ROUTER -- requirements
Module: trigger_router

---
 rtl/trigger_router.sv | 108 ++++++++++
 tb/tb_trigger_router.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/trigger_router.sv
// trigger_router: synchronizes trigger inputs and routes them to outputs through per-channel PASS/STRETCH/TOGGLE logic
// with shadow configuration that is applied atomically on commit.
module trigger_router #(
  parameter int NUM_IN       = 12,
  parameter int NUM_OUT      = 12,
  parameter int STRETCH_BITS = 16,
  localparam int CW = NUM_OUT > 1 ? $clog2(NUM_OUT) : 1,
  localparam int SW = NUM_IN > 1 ? $clog2(NUM_IN) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN-1:0]       trig_in,
  input  logic                    cfg_wr_en,
  input  logic [CW-1:0]           cfg_wr_chan,
  input  logic [SW-1:0]           cfg_wr_src,
  input  logic [1:0]              cfg_wr_mode,
  input  logic                    cfg_wr_invert,
  input  logic [STRETCH_BITS-1:0] cfg_wr_len,
  input  logic                    cfg_commit,
  output logic                    cfg_err,
  output logic [NUM_OUT-1:0]      trig_out
);
  typedef enum logic [1:0] {M_OFF, M_PASS, M_STRETCH, M_TOGGLE} mode_t;

  logic [NUM_IN-1:0] r_sync1, r_sync2, r_prev;
  logic [NUM_IN-1:0] w_rise;
  logic              w_wr_ok;

  assign w_rise  = r_sync2 & ~r_prev;
  assign w_wr_ok = cfg_wr_en && ({1'b0, cfg_wr_chan} < (CW+1)'(NUM_OUT)) &&
                   ({1'b0, cfg_wr_src} < (SW+1)'(NUM_IN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
      cfg_err <= 1'b0;
    end else begin
      r_sync1 <= trig_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      cfg_err <= cfg_wr_en && !w_wr_ok;
    end
  end

  for (genvar c = 0; c < NUM_OUT; c++) begin : g_ch
    logic [SW-1:0]           r_sh_src, r_ac_src, w_sh_src;
    mode_t                   r_sh_mode, r_ac_mode, w_sh_mode;
    logic                    r_sh_inv, r_ac_inv, w_sh_inv;
    logic [STRETCH_BITS-1:0] r_sh_len, r_ac_len, w_sh_len;
    logic [STRETCH_BITS-1:0] r_cnt, w_cnt_nxt, w_len_eff;
    logic                    r_tog, w_tog_nxt, w_hit, w_lvl, w_edge, w_res, r_out;

    assign w_hit = w_wr_ok && cfg_wr_chan == CW'(c);

    // the next-shadow view lets a write in the commit cycle reach the active set
    always_comb begin
      w_sh_src  = w_hit ? cfg_wr_src : r_sh_src;
      w_sh_mode = w_hit ? mode_t'(cfg_wr_mode) : r_sh_mode;
      w_sh_inv  = w_hit ? cfg_wr_invert : r_sh_inv;
      w_sh_len  = w_hit ? cfg_wr_len : r_sh_len;
      w_lvl     = r_sync2[r_ac_src];
      w_edge    = w_rise[r_ac_src];
      w_len_eff = r_ac_len == '0 ? STRETCH_BITS'(1) : r_ac_len;
      w_cnt_nxt = w_edge ? w_len_eff : (r_cnt != '0 ? r_cnt - STRETCH_BITS'(1) : '0);
      w_tog_nxt = r_tog ^ w_edge;
      w_res     = r_ac_mode == M_PASS ? w_lvl :
                  r_ac_mode == M_STRETCH ? (w_cnt_nxt != '0) : w_tog_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sh_src  <= '0;
        r_sh_mode <= M_OFF;
        r_sh_inv  <= 1'b0;
        r_sh_len  <= '0;
        r_ac_src  <= '0;
        r_ac_mode <= M_OFF;
        r_ac_inv  <= 1'b0;
        r_ac_len  <= '0;
        r_cnt     <= '0;
        r_tog     <= 1'b0;
        r_out     <= 1'b0;
      end else begin
        r_sh_src  <= w_sh_src;
        r_sh_mode <= w_sh_mode;
        r_sh_inv  <= w_sh_inv;
        r_sh_len  <= w_sh_len;
        if (cfg_commit) begin
          r_ac_src  <= w_sh_src;
          r_ac_mode <= w_sh_mode;
          r_ac_inv  <= w_sh_inv;
          r_ac_len  <= w_sh_len;
          r_cnt     <= '0;
          r_tog     <= 1'b0;
          r_out     <= 1'b0;
        end else begin
          r_cnt <= w_cnt_nxt;
          r_tog <= w_tog_nxt;
          r_out <= r_ac_mode == M_OFF ? 1'b0 : w_res ^ r_ac_inv;
        end
      end
    end

    assign trig_out[c] = r_out;
  end
endmodule

// File: tb/tb_trigger_router.sv
// tb_trigger_router: random and directed stimulus checked every cycle against an event-time reference model.
module tb_trigger_router;
  localparam int NI = 12, NO = 12, SB = 16;

  logic          clk = 0, rst_n = 0;
  logic [NI-1:0] trig_in = '0;
  logic          cfg_wr_en = 0, cfg_wr_invert = 0, cfg_commit = 0;
  logic [3:0]    cfg_wr_chan = '0, cfg_wr_src = '0;
  logic [1:0]    cfg_wr_mode = '0;
  logic [SB-1:0] cfg_wr_len = '0;
  logic          cfg_err;
  logic [NO-1:0] trig_out;

  trigger_router #(.NUM_IN(NI), .NUM_OUT(NO), .STRETCH_BITS(SB)) dut (
    .clk(clk), .rst_n(rst_n), .trig_in(trig_in), .cfg_wr_en(cfg_wr_en),
    .cfg_wr_chan(cfg_wr_chan), .cfg_wr_src(cfg_wr_src), .cfg_wr_mode(cfg_wr_mode),
    .cfg_wr_invert(cfg_wr_invert), .cfg_wr_len(cfg_wr_len), .cfg_commit(cfg_commit),
    .cfg_err(cfg_err), .trig_out(trig_out)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: outputs derived from the sampled input history and the time of each channel's last source edge.
  logic [NI-1:0] hist[$];
  int            sh_src[NO], sh_mode[NO], sh_inv[NO], sh_len[NO];
  int            ac_src[NO], ac_mode[NO], ac_inv[NO], ac_len[NO];
  int            last[NO];
  bit            tog[NO];
  logic [NO-1:0] exp_out = '0;
  logic          exp_err = 0;
  int            n = 0, ms;
  logic [NI-1:0] lvl, pl;
  bit            mr, mv;

  function automatic void mreset();
    hist.delete();
    repeat (3) hist.push_back('0);
    for (int c = 0; c < NO; c++) begin
      sh_src[c] = 0; sh_mode[c] = 0; sh_inv[c] = 0; sh_len[c] = 0;
      ac_src[c] = 0; ac_mode[c] = 0; ac_inv[c] = 0; ac_len[c] = 0;
      last[c] = -1000000; tog[c] = 0;
    end
    exp_out = '0;
    exp_err = 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mreset();
    else begin
      n++;
      hist.push_back(trig_in);
      if (hist.size() > 8) void'(hist.pop_front());
      lvl = hist[hist.size()-3];
      pl  = hist[hist.size()-4];
      exp_err = cfg_wr_en && (cfg_wr_chan >= NO || cfg_wr_src >= NI);
      if (cfg_wr_en && !exp_err) begin
        sh_src[cfg_wr_chan]  = cfg_wr_src;
        sh_mode[cfg_wr_chan] = cfg_wr_mode;
        sh_inv[cfg_wr_chan]  = cfg_wr_invert;
        sh_len[cfg_wr_chan]  = cfg_wr_len;
      end
      for (int c = 0; c < NO; c++) begin
        if (cfg_commit) begin
          ac_src[c] = sh_src[c]; ac_mode[c] = sh_mode[c];
          ac_inv[c] = sh_inv[c]; ac_len[c] = sh_len[c];
          last[c] = -1000000; tog[c] = 0; exp_out[c] = 0;
        end else begin
          ms = ac_src[c];
          mr = lvl[ms] && !pl[ms];
          if (mr) begin last[c] = n; tog[c] = !tog[c]; end
          case (ac_mode[c])
            1: mv = lvl[ms];
            2: mv = (n - last[c]) < (ac_len[c] == 0 ? 1 : ac_len[c]);
            3: mv = tog[c];
            default: mv = 0;
          endcase
          exp_out[c] = ac_mode[c] == 0 ? 1'b0 : mv ^ ac_inv[c][0];
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("model_trig_out", trig_out, exp_out);
    chk("model_cfg_err", cfg_err, exp_err);
  end

  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wr(input int ch, input int src, input int mode, input int inv, input int len, input bit com);
    cfg_wr_en = 1; cfg_wr_chan = ch[3:0]; cfg_wr_src = src[3:0]; cfg_wr_mode = mode[1:0];
    cfg_wr_invert = inv[0]; cfg_wr_len = len[SB-1:0]; cfg_commit = com;
    @(negedge clk);
    cfg_wr_en = 0; cfg_commit = 0;
  endtask

  task automatic commit();
    cfg_commit = 1;
    @(negedge clk);
    cfg_commit = 0;
  endtask

  task automatic meas(input int ch, input int bi, input int second,
                      output int first, output int width, output int rises);
    bit b, p;
    first = -1; width = 0; rises = 0; p = 0;
    trig_in[bi] = 1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      b = trig_out[ch];
      if (b) begin width++; if (first < 0) first = i; end
      if (b && !p) rises++;
      p = b;
      if (i == 1) trig_in[bi] = 0;
      if (second > 0 && i == second) trig_in[bi] = 1;
      if (second > 0 && i == second + 1) trig_in[bi] = 0;
    end
  endtask

  int f, w, r;
  int tseq[3] = '{0, 1, 0};

  initial begin
    idle(3);
    chk("reset_out", trig_out, 0);
    chk("reset_err", cfg_err, 0);
    rst_n = 1;
    repeat (10) begin trig_in = NI'($urandom); @(negedge clk); end
    chk("precommit_out", trig_out, 0);
    trig_in = '0;
    idle(4);

    wr(3, 7, 1, 0, 0, 0); commit(); idle(4);
    trig_in[7] = 1;
    @(negedge clk); chk("pass_t1", trig_out, 0);
    @(negedge clk); chk("pass_t2", trig_out, 0);
    @(negedge clk); chk("pass_t3", trig_out, 12'h008);
    trig_in = '0; idle(4);

    wr(0, 0, 2, 0, 5, 0); commit(); idle(4);
    meas(0, 0, 0, f, w, r);
    chk("str5_first", f, 3); chk("str5_width", w, 5); chk("str5_rises", r, 1);
    wr(0, 0, 2, 0, 0, 0); commit(); idle(4);
    meas(0, 0, 0, f, w, r);
    chk("str0_first", f, 3); chk("str0_width", w, 1);

    wr(0, 0, 2, 0, 10, 0); commit(); idle(4);
    meas(0, 0, 4, f, w, r);
    chk("retrig_first", f, 3); chk("retrig_width", w, 14); chk("retrig_rises", r, 1);

    wr(12, 0, 1, 0, 0, 0); chk("err_chan", cfg_err, 1);
    @(negedge clk); chk("err_chan_clr", cfg_err, 0);
    wr(1, 12, 1, 0, 0, 0); chk("err_src", cfg_err, 1);
    @(negedge clk); chk("err_src_clr", cfg_err, 0);
    commit(); idle(4);
    meas(0, 0, 0, f, w, r);
    chk("err_keep_width", w, 10);
    chk("err_keep_ch1", trig_out[1], 0);

    wr(1, 2, 3, 1, 0, 1); idle(2);
    chk("tog_init", trig_out[1], 1);
    for (int k = 0; k < 3; k++) begin
      trig_in[2] = 1; idle(2); trig_in[2] = 0; idle(4);
      chk("tog_seq", trig_out[1], tseq[k]);
    end

    repeat (3000) begin
      trig_in = trig_in ^ (NI'($urandom) & NI'($urandom) & NI'($urandom));
      cfg_wr_en = ($urandom_range(0, 7) == 0);
      cfg_wr_chan = 4'($urandom_range(0, 12));
      cfg_wr_src = 4'($urandom_range(0, 12));
      cfg_wr_mode = 2'($urandom);
      cfg_wr_invert = 1'($urandom);
      cfg_wr_len = SB'($urandom_range(0, 15));
      cfg_commit = ($urandom_range(0, 29) == 0);
      @(negedge clk);
    end
    cfg_wr_en = 0; cfg_commit = 0; trig_in = '0;
    idle(4);

    wr(0, 0, 2, 0, 100, 0); commit(); idle(4);
    trig_in[0] = 1; idle(1); trig_in[0] = 0; idle(8);
    chk("pre_rst", trig_out[0], 1);
    #2 rst_n = 0;
    #1 chk("async_rst", trig_out, 0);
    idle(2);
    rst_n = 1;
    repeat (10) begin trig_in = NI'($urandom); @(negedge clk); end
    chk("post_rst", trig_out, 0);
    commit(); idle(5);
    chk("post_rst_commit", trig_out, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
